tt_sweep_ctrl: RTL
==================

// Module: tt_sweep_ctrl
// PURPOSE
//  Sequencer that exhaustively sweeps all 2**N_IN input vectors into one N_IN-input
//  logic-network instance under test and assembles its truth table.
//  Captured bits go to tt; tt is then compared to an expected table and its weight is counted.
//  Sits between the classification test harness and a synthesized network (x0..x6 -> out).
// PARAMETERS
//  N_IN     7   number of network inputs; table width TT_W = 2**N_IN
//  DUT_LAT  0   cycles from x driven to f_in valid (0 = combinational network); range 0..7
// PORTS
//  clk       in   1         rising-edge clock
//  rst_n     in   1         asynchronous active-low reset
//  start     in   1         begin sweep; sampled only in IDLE
//  abort     in   1         cancel sweep; return to IDLE, no done
//  expected  in   TT_W      reference truth table; bit i = f(x=i); sampled at DONE
//  f_in      in   1         network output for the vector issued DUT_LAT cycles earlier
//  x         out  N_IN      registered input vector to network; x[0] drives x0
//  busy      out  1         high in SWEEP and DRAIN
//  done      out  1         one-cycle pulse when results valid
//  tt        out  TT_W      captured truth table; bit i = f_in for x=i
//  ones_cnt  out  N_IN+1    popcount of tt (0..TT_W)
//  match     out  1         tt == expected; registered with done, held
// BEHAVIOUR
//  Reset: state=IDLE; x, tt, ones_cnt = 0; busy, done, match = 0; delay line cleared.
//  FSM IDLE -> SWEEP -> DRAIN -> DONE -> IDLE.
//  - IDLE: start=1 & abort=0 -> SWEEP. Same edge: idx=0, tt=0, ones_cnt=0, match=0.
//    start & abort together in IDLE: abort wins; stay IDLE.
//  - SWEEP: x=idx each cycle; idx++. After vector TT_W-1 is issued -> DRAIN.
//    x holds TT_W-1 in DRAIN.
//  - Capture: delay line of DUT_LAT (valid,idx) stages.
//    At each edge with a valid tap: tt[idx_tap] <= f_in; ones_cnt += f_in.
//    DUT_LAT=0: capture uses the current x.
//  - DRAIN: wait until the last valid tap (idx TT_W-1) is captured -> DONE.
//  - DONE: done=1 for exactly one cycle; match <= (tt == expected); busy=0; -> IDLE.
//  Timing: the start edge is E0. Vector k is on x after edge E(k); its bit is captured at E(k+1+DUT_LAT).
//    done and match become visible after E(TT_W+1+DUT_LAT); with defaults that is 129.
//  Results (tt, ones_cnt, match) hold after done until the next accepted start.
//  start while busy: ignored, no restart.
//  abort in SWEEP/DRAIN: next state IDLE; delay line flushed; no done.
//    tt and ones_cnt keep their partial values; match=0.
//  rst_n low mid-sweep: immediate return to reset values; no done.
//  idx counter is N_IN+1 bits wide, so the terminal compare cannot alias on wrap-around.
//  ones_cnt never exceeds TT_W.
// CONFIGURATION
//  SELF_DUAL_CHK_EN defined: adds output self_dual (1 bit, reset 0).
//    self_dual is registered with done as AND over i of (tt[i] != tt[TT_W-1-i]),
//    i.e. f(~x) == ~f(x). It is held like match and cleared by an accepted start or an abort.
//  Undefined: no self_dual port and no related logic.
// TESTING
//  1 Combinational majority network with truth table 128'hfee8eaa8eaa8eaa8eaa8eaa8eaa8e880;
//    expected = same value ->
//    tt = 128'hfee8...e880, ones_cnt=64, match=1, done after E129.
//  2 f_in tied 0; expected=0 -> tt=0, ones_cnt=0, match=1; with SELF_DUAL_CHK_EN, self_dual=0.
//  3 f_in=x[0], DUT_LAT=3 -> tt = {32{4'ha}}, ones_cnt=64, done after E132;
//    with SELF_DUAL_CHK_EN, self_dual=1.
//  4 abort at the cycle x=50 ->
//    no done; busy=0 next cycle; tt bits 0..49 as captured, bits above 49 = 0; match=0.
//    A following start completes normally.
//  5 start pulsed again at x=10, plus start&abort together in IDLE ->
//    first: ignored, and a single done arrives on time; second: stays IDLE.
//  6 rst_n asserted at x=100, released, then start ->
//    outputs at reset values during reset; a fresh full sweep completes with correct tt.

Source files
------------

// File: rtl/tt_sweep_ctrl.sv
// Sweeps all 2**N_IN input vectors into a logic network and assembles its truth table.
// Define SELF_DUAL_CHK_EN to add the self_dual result flag.
module tt_sweep_ctrl #(
  parameter int  N_IN    = 7,
  parameter int  DUT_LAT = 0,
  localparam int TT_W    = 1 << N_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [TT_W-1:0]   expected,
  input  logic              f_in,
  output logic [N_IN-1:0]   x,
  output logic              busy,
  output logic              done,
  output logic [TT_W-1:0]   tt,
  output logic [N_IN:0]     ones_cnt,
  output logic              match
`ifdef SELF_DUAL_CHK_EN
  ,
  output logic              self_dual
`endif
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t          state;
  logic [N_IN:0]   idx;      // next vector to put on x; one bit wider than x
  logic            issue_v;  // x carries a vector that still has to enter the delay line
  logic            tap_v;
  logic [N_IN-1:0] tap_idx;
  logic            flush;
  logic            last_tap;

  assign flush    = abort && (state == SWEEP || state == DRAIN);
  assign last_tap = tap_v && (tap_idx == N_IN'(TT_W - 1));

  if (DUT_LAT == 0) begin : g_no_delay
    assign tap_v   = issue_v;
    assign tap_idx = x;
  end else begin : g_delay
    logic [DUT_LAT-1:0] dl_v;
    logic [N_IN-1:0]    dl_idx [DUT_LAT];

    // NOTE: the index payload is reset along with the valid bits so the line is fully defined after reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dl_v <= '0;
        for (int i = 0; i < DUT_LAT; i++) dl_idx[i] <= '0;
      end else begin
        dl_v[0]   <= issue_v && !flush;
        dl_idx[0] <= x;
        for (int i = 1; i < DUT_LAT; i++) begin
          dl_v[i]   <= dl_v[i-1] && !flush;
          dl_idx[i] <= dl_idx[i-1];
        end
      end
    end

    assign tap_v   = dl_v[DUT_LAT-1];
    assign tap_idx = dl_idx[DUT_LAT-1];
  end

`ifdef SELF_DUAL_CHK_EN
  logic sd_now;

  // f(~x) == ~f(x): mirrored table bits must differ; checking one half covers every pair.
  always_comb begin
    // NOTE: give every always_comb output a default before the loop so no latch is inferred.
    sd_now = 1'b1;
    for (int i = 0; i < TT_W / 2; i++) sd_now = sd_now & (tt[i] != tt[TT_W-1-i]);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      issue_v  <= 1'b0;
      x        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt       <= '0;
      ones_cnt <= '0;
      match    <= 1'b0;
`ifdef SELF_DUAL_CHK_EN
      self_dual <= 1'b0;
`endif
    end else begin
      // NOTE: state uses non-blocking assignments only, so every read sees the pre-edge value.
      done <= 1'b0;

      if (tap_v && !flush) begin
        tt[tap_idx] <= f_in;
        ones_cnt    <= ones_cnt + {{N_IN{1'b0}}, f_in};
      end

      case (state)
        IDLE: begin
          if (start && !abort) begin
            state    <= SWEEP;
            x        <= '0;
            idx      <= (N_IN+1)'(1);
            issue_v  <= 1'b1;
            busy     <= 1'b1;
            tt       <= '0;
            ones_cnt <= '0;
            match    <= 1'b0;
`ifdef SELF_DUAL_CHK_EN
            self_dual <= 1'b0;
`endif
          end
        end
        SWEEP: begin
          x   <= idx[N_IN-1:0];
          idx <= idx + (N_IN+1)'(1);
          if (idx == (N_IN+1)'(TT_W - 1)) state <= DRAIN;
        end
        DRAIN: begin
          issue_v <= 1'b0;
          if (last_tap) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b1;
          match <= (tt == expected);
`ifdef SELF_DUAL_CHK_EN
          self_dual <= sd_now;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Abort leaves the partial table and count in place but drops every pending capture.
      if (flush) begin
        state   <= IDLE;
        busy    <= 1'b0;
        issue_v <= 1'b0;
        match   <= 1'b0;
`ifdef SELF_DUAL_CHK_EN
        self_dual <= 1'b0;
`endif
      end
    end
  end

endmodule
